stream_unpacker: RTL and testbench

Receive-side counterpart to the pixel packer. Accepts a 32-bit AXI-Stream video stream carrying packed 24-bit RGB pixels: 4 pixels per 3 words, `tuser` marking start-of-frame and `tlast` marking end-of-line. Emits one pixel per handshake with x/y coordinates and SOF/EOL flags to a downstream pixel consumer, such as a frame-capture or line-buffer writer. Checks the framing and resynchronises on errors.

---
 rtl/stream_unpacker.sv | 242 ++++++++++++++++++++++++
 tb/tb_stream_unpacker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_unpacker.sv
// Unpacks a 32-bit AXI-Stream of packed 24-bit RGB (4 pixels per 3 words) into one
// pixel per handshake with x/y, SOF/EOL flags, framing checks and resync on errors.
//   state | meaning
//   SYNC  | dropping words until one carries tuser (frame word 0)
//   RUN   | accepting words; each word loads the output register
//   DRAIN | second pixel of a phase-2 word (or a parked SOF pixel) waits for the slot
module stream_unpacker #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [31:0]               in_stream_tdata,
  input  logic [3:0]                in_stream_tkeep,
  input  logic                      in_stream_tlast,
  input  logic                      in_stream_tuser,
  input  logic                      in_stream_tvalid,
  output logic                      in_stream_tready,
  output logic [7:0]                r,
  output logic [7:0]                g,
  output logic [7:0]                b,
  output logic [$clog2(X_SIZE)-1:0] x,
  output logic [$clog2(Y_SIZE)-1:0] y,
  output logic                      sof,
  output logic                      eol,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      frame_done,
  output logic                      err_eol_early,
  output logic                      err_eol_late,
  output logic                      err_sof,
  input  logic                      err_clear,
  output logic [15:0]               frame_count
);

  localparam int WPL = X_SIZE * 3 / 4;
  localparam int XW  = $clog2(X_SIZE);
  localparam int YW  = $clog2(Y_SIZE);
  localparam int WW  = $clog2(WPL);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WPL - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [YW-1:0] line;
  logic [1:0]    phase;
  logic [15:0]   held;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [23:0]   pend;
  logic [XW-1:0] pend_x;
  logic [YW-1:0] pend_y;
  logic          to_sync;

  logic          out_free;
  logic          acc;
  logic          take;
  logic          restart;
  logic          in_run;
  logic [WW-1:0] e_wcnt;
  logic [YW-1:0] e_line;
  logic [1:0]    e_phase;
  logic [XW-1:0] e_x;
  logic [YW-1:0] e_y;
  logic          last_word;
  logic          set_early;
  logic          set_late;
  logic          set_sof;
  logic          stop;
  logic [23:0]   pix_a;
  logic [23:0]   pix_b;
  logic [15:0]   n_held;
  logic [XW-1:0] bx;
  logic [YW-1:0] by;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [WW-1:0] n_wcnt;
  logic [YW-1:0] n_line;
  logic [1:0]    n_phase;
  logic          ld;
  logic [23:0]   ld_pix;
  logic [XW-1:0] ld_x;
  logic [YW-1:0] ld_y;
  logic          last_acc;

  logic unused_keep;
  assign unused_keep = ^in_stream_tkeep;

  function automatic logic [XW+YW-1:0] step(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    if (cx == X_LAST) begin
      sx = '0;
      sy = (cy == Y_LAST) ? '0 : cy + YW'(1);
    end else begin
      sx = cx + XW'(1);
      sy = cy;
    end
    return {sx, sy};
  endfunction

  assign out_free         = !pix_valid || pix_ready;
  assign in_stream_tready = aresetn && ((state == SYNC) || (state == RUN && out_free));

  always_comb begin
    acc       = in_stream_tvalid && in_stream_tready;
    take      = acc && (state == RUN || in_stream_tuser);
    // a tuser word always becomes word 0 of a fresh frame, in SYNC or mid-frame
    restart   = (state == SYNC) || in_stream_tuser;
    in_run    = take && (state == RUN);
    e_wcnt    = restart ? '0 : wcnt;
    e_line    = restart ? '0 : line;
    e_phase   = restart ? 2'd0 : phase;
    e_x       = restart ? '0 : px;
    e_y       = restart ? '0 : py;
    last_word = (e_wcnt == W_LAST);
    set_sof   = in_run && in_stream_tuser && (wcnt != '0 || line != '0);
    set_early = in_run && in_stream_tlast && !last_word;
    set_late  = in_run && last_word && !in_stream_tlast;
    stop      = set_early || set_late || (last_word && e_line == Y_LAST);

    case (e_phase)
      2'd0:    pix_a = in_stream_tdata[23:0];
      2'd1:    pix_a = {in_stream_tdata[15:0], held[7:0]};
      default: pix_a = {in_stream_tdata[7:0], held};
    endcase
    pix_b  = in_stream_tdata[31:8];
    n_held = (e_phase == 2'd0) ? {8'h00, in_stream_tdata[31:24]} : in_stream_tdata[31:16];

    {bx, by} = step(e_x, e_y);
    {nx, ny} = (e_phase == 2'd2) ? step(bx, by) : {bx, by};

    n_wcnt  = last_word ? '0 : e_wcnt + WW'(1);
    n_line  = last_word ? ((e_line == Y_LAST) ? '0 : e_line + YW'(1)) : e_line;
    n_phase = (e_phase == 2'd2) ? 2'd0 : e_phase + 2'd1;

    ld     = out_free && (take || state == DRAIN);
    ld_pix = (state == DRAIN) ? pend : pix_a;
    ld_x   = (state == DRAIN) ? pend_x : e_x;
    ld_y   = (state == DRAIN) ? pend_y : e_y;

    last_acc = pix_valid && pix_ready && (x == X_LAST) && (y == Y_LAST);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= SYNC;
      wcnt          <= '0;
      line          <= '0;
      phase         <= 2'd0;
      held          <= '0;
      px            <= '0;
      py            <= '0;
      pend          <= '0;
      pend_x        <= '0;
      pend_y        <= '0;
      to_sync       <= 1'b0;
      pix_valid     <= 1'b0;
      r             <= '0;
      g             <= '0;
      b             <= '0;
      x             <= '0;
      y             <= '0;
      sof           <= 1'b0;
      eol           <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
      err_sof       <= 1'b0;
    end else begin
      frame_done <= last_acc;
      if (last_acc) frame_count <= frame_count + 16'd1;

      err_eol_early <= set_early || (err_eol_early && !err_clear);
      err_eol_late  <= set_late  || (err_eol_late  && !err_clear);
      err_sof       <= set_sof   || (err_sof       && !err_clear);

      if (ld) begin
        pix_valid <= 1'b1;
        {b, g, r} <= ld_pix;
        x         <= ld_x;
        y         <= ld_y;
        sof       <= (ld_x == '0) && (ld_y == '0);
        eol       <= (ld_x == X_LAST);
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end

      if (take) begin
        wcnt  <= n_wcnt;
        line  <= n_line;
        phase <= n_phase;
        held  <= n_held;
        px    <= nx;
        py    <= ny;
      end

      case (state)
        SYNC: begin
          // the SOF word may arrive while the last pixel of the old frame is still stalled
          if (take) begin
            if (out_free) begin
              state <= RUN;
            end else begin
              pend    <= pix_a;
              pend_x  <= e_x;
              pend_y  <= e_y;
              to_sync <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        RUN: begin
          if (take) begin
            if (e_phase == 2'd2) begin
              pend    <= pix_b;
              pend_x  <= bx;
              pend_y  <= by;
              to_sync <= stop;
              state   <= DRAIN;
            end else if (stop) begin
              state <= SYNC;
            end
          end
        end
        DRAIN: begin
          if (out_free) state <= to_sync ? SYNC : RUN;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker on a small frame: reset/latency, throughput, framing-fault
// table and randomized throttled frames checked against a byte-level pixel model.
module tb_stream_unpacker;

  localparam int X     = 16;
  localparam int Y     = 6;
  localparam int WPL   = X * 3 / 4;
  localparam int NPIX  = X * Y;
  localparam int NWORD = WPL * Y;
  localparam int XW    = $clog2(X);
  localparam int YW    = $clog2(Y);

  localparam int K_CLEAN = 0;
  localparam int K_EARLY = 1;
  localparam int K_LATE  = 2;
  localparam int K_SOF   = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic          tlast;
  logic          tuser;
  logic          tvalid;
  logic          tready;
  logic [7:0]    r, g, b;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sof, eol, pix_valid, pix_ready, frame_done;
  logic          err_eol_early, err_eol_late, err_sof, err_clear;
  logic [15:0]   frame_count;

  always #5 aclk = ~aclk;

  stream_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .in_stream_tdata (tdata),
    .in_stream_tkeep (tkeep),
    .in_stream_tlast (tlast),
    .in_stream_tuser (tuser),
    .in_stream_tvalid(tvalid),
    .in_stream_tready(tready),
    .r               (r),
    .g               (g),
    .b               (b),
    .x               (x),
    .y               (y),
    .sof             (sof),
    .eol             (eol),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .frame_done      (frame_done),
    .err_eol_early   (err_eol_early),
    .err_eol_late    (err_eol_late),
    .err_sof         (err_sof),
    .err_clear       (err_clear),
    .frame_count     (frame_count)
  );

  typedef struct packed {
    logic [7:0]    r;
    logic [7:0]    g;
    logic [7:0]    b;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic          s;
    logic          e;
  } pix_t;

  typedef struct {
    int kind;
    int line;
    int word;
    bit e_early;
    bit e_late;
    bit e_sof;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  bit         throttle = 1'b0;
  bit         log_tr = 1'b0;
  bit         tr_log[$];
  pix_t       got[$];
  logic [7:0] fb [0:NPIX*3-1];
  int         fd_cnt = 0;
  int         stall_checks = 0;
  int         stall_viol = 0;
  int         exp_frames = 0;
  vec_t       vecs [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit u, input bit l, input bit gaps);
    bit hs;
    int n;
    n = 0;
    if (gaps && $urandom_range(3) == 0) begin
      tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    do begin
      @(negedge aclk);
      hs = tready;
      if (log_tr) tr_log.push_back(hs);
      @(posedge aclk); #1;
      n++;
      if (!hs && n > 500) begin
        errors++;
        $display("FAIL tready_timeout: no handshake after %0d cycles", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "handshake timeout");
      end
    end while (!hs);
    tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit th;
    th = throttle;
    throttle = 1'b0;
    tvalid = 1'b0;
    repeat (8) @(posedge aclk);
    #1;
    throttle = th;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge aclk); #1;
    err_clear = 1'b0;
  endtask

  task automatic fill_frame(input bit rnd);
    for (int i = 0; i < NPIX*3; i++) fb[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < NWORD; k++)
      send_word({fb[4*k+3], fb[4*k+2], fb[4*k+1], fb[4*k]}, k == 0, (k % WPL) == WPL-1, gaps);
  endtask

  // Model: the frame's byte string cut into 3-byte pixels in raster order.
  task automatic check_frame(input string name);
    pix_t e;
    int   bad, fi;
    bad = 0; fi = -1;
    chk({name, "_count"}, got.size(), NPIX);
    for (int i = 0; i < NPIX && i < got.size(); i++) begin
      e.r  = fb[3*i];
      e.g  = fb[3*i+1];
      e.b  = fb[3*i+2];
      e.px = XW'(i % X);
      e.py = YW'(i / X);
      e.s  = (i == 0);
      e.e  = ((i % X) == X-1);
      if (got[i] != e) begin
        bad++;
        if (fi < 0) begin
          fi = i;
          $display("  first bad pixel %0d of %s: got %h expected %h", i, name, got[i], e);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pixels: %0d bad pixels, first at %0d, required 0", name, bad, fi);
    end
  endtask

  // output monitor: collects accepted pixels and checks hold-while-stalled
  initial begin
    pix_t cur, snap;
    bit   stall_prev;
    stall_prev = 1'b0;
    snap = '0;
    pix_ready = 1'b1;
    forever begin
      @(negedge aclk);
      cur = {r, g, b, x, y, sof, eol};
      if (stall_prev) begin
        stall_checks++;
        if (!pix_valid || cur != snap) stall_viol++;
      end
      if (aresetn && pix_valid && pix_ready) got.push_back(cur);
      stall_prev = aresetn && pix_valid && !pix_ready;
      snap = cur;
      if (frame_done) fd_cnt++;
      @(posedge aclk); #1;
      pix_ready = throttle ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    int fd0, bad, first;
    bit lst;
    vec_t v;

    vecs[0] = '{K_CLEAN, 0,     0,       0, 0, 0};
    vecs[1] = '{K_EARLY, 3,     5,       1, 0, 0};
    vecs[2] = '{K_LATE,  0,     WPL-1,   0, 1, 0};
    vecs[3] = '{K_SOF,   2,     7,       0, 0, 1};
    vecs[4] = '{K_EARLY, 1,     0,       1, 0, 0};
    vecs[5] = '{K_SOF,   0,     1,       0, 0, 1};
    vecs[6] = '{K_EARLY, Y-1,   WPL-2,   1, 0, 0};
    vecs[7] = '{K_LATE,  2,     WPL-1,   0, 1, 0};

    aresetn = 1'b0; tvalid = 1'b1; tdata = 32'hDEADBEEF; tuser = 1'b1; tlast = 1'b0;
    tkeep = 4'hF; err_clear = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tready", tready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_flags", {err_eol_early, err_eol_late, err_sof, frame_done, sof, eol}, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_xyrgb", {x, y, r, g, b}, 0);
    tvalid = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_tready", tready, 1);

    // first pixel appears one cycle after its word is accepted
    @(posedge aclk); #1;
    tdata = 32'h44332211; tuser = 1'b1; tlast = 1'b0; tvalid = 1'b1;
    @(negedge aclk);
    chk("lat_tready", tready, 1);
    chk("lat_pre_valid", pix_valid, 0);
    @(posedge aclk); #1 tvalid = 1'b0;
    @(negedge aclk);
    chk("lat_valid", pix_valid, 1);
    chk("lat_rgb", {r, g, b}, 24'h112233);
    chk("lat_sof_xy", {sof, x, y}, {1'b1, XW'(0), YW'(0)});

    // reset mid-frame with held bytes and a pending pixel B
    @(posedge aclk); #1;
    send_word(32'h77665544, 1'b0, 1'b0, 1'b0);
    send_word(32'hBBAA9988, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midrst_tready", tready, 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("midrst_valid", pix_valid, 0);
    @(posedge aclk); #1 aresetn = 1'b1;

    wait_idle();
    got.delete();
    fd0 = fd_cnt;
    fill_frame(1'b0);
    log_tr = 1'b1;
    send_frame(1'b0);
    log_tr = 1'b0;
    wait_idle();
    check_frame("clean_inc");
    exp_frames++;
    chk("clean_frame_count", frame_count, exp_frames);
    chk("clean_done_pulses", fd_cnt - fd0, 1);
    chk("clean_flags", {err_eol_early, err_eol_late, err_sof}, 0);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (i >= tr_log.size() || tr_log[i] != ((i % 4) != 3)) bad++;
    chk("tready_pattern_1110", bad, 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      throttle = i[0];
      pulse_clear();
      if (v.kind != K_CLEAN) begin
        first = 1;
        for (int ln = 0; ln <= v.line; ln++)
          for (int w = 0; w < WPL; w++) begin
            if (ln == v.line && (w > v.word || (v.kind == K_SOF && w == v.word))) break;
            lst = (ln < v.line) ? (w == WPL-1) : (v.kind == K_EARLY && w == v.word);
            send_word($urandom, first != 0, lst, 1'b1);
            first = 0;
          end
      end
      wait_idle();
      got.delete();
      if (v.kind == K_EARLY || v.kind == K_LATE) begin
        for (int j = 0; j < 3; j++) send_word($urandom, 1'b0, 1'($urandom_range(1)), 1'b1);
        wait_idle();
      end
      fd0 = fd_cnt;
      fill_frame(1'b1);
      send_frame(1'b1);
      wait_idle();
      check_frame($sformatf("row%0d", i));
      exp_frames++;
      chk($sformatf("row%0d_frame_count", i), frame_count, exp_frames);
      chk($sformatf("row%0d_done_pulses", i), fd_cnt - fd0, 1);
      chk($sformatf("row%0d_err_early", i), err_eol_early, v.e_early);
      chk($sformatf("row%0d_err_late", i), err_eol_late, v.e_late);
      chk($sformatf("row%0d_err_sof", i), err_sof, v.e_sof);
      pulse_clear();
      @(negedge aclk);
      chk($sformatf("row%0d_cleared", i), {err_eol_early, err_eol_late, err_sof}, 0);
      @(posedge aclk); #1;
    end

    throttle = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fill_frame(1'b1);
      got.delete();
      fd0 = fd_cnt;
      send_frame(1'b1);
      wait_idle();
      check_frame($sformatf("rand%0d", f));
      exp_frames++;
      chk($sformatf("rand%0d_frame_count", f), frame_count, exp_frames);
      chk($sformatf("rand%0d_done_pulses", f), fd_cnt - fd0, 1);
    end
    throttle = 1'b0;
    chk("stall_hold_violations", stall_viol, 0);
    chk("stall_seen", stall_checks > 0, 1);
    chk("final_flags", {err_eol_early, err_eol_late, err_sof}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
